// File: rtl/mac_accum8.sv
// mac_accum8: streaming multiply-accumulate stage fed by an 8x8 unsigned multiplier.
// Operand beats (a, b, in_last) arrive on an in_valid/in_ready handshake. Each product
// is registered, then summed into a packet accumulator. The packet result is held on an
// out_valid/out_ready handshake until the consumer takes it.
//
// Parameters:
//   ACC_W  accumulator/result width (must be >= 16)
//   CNT_W  beat-counter width
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand beat handshake (in_ready is combinational)
//   a, b                unsigned 8-bit operands
//   in_last             final beat of the packet
//   out_valid/out_ready result handshake
//   acc_out             packet sum of products, modulo 2^ACC_W
//   out_count           beats in the packet, modulo 2^CNT_W
//   overflow            accumulator carried out at least once during the packet

// Purely combinational 8x8 unsigned multiplier.
module multi8 (
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   output logic [15:0] p_o
);
   assign p_o = 16'(a_i) * 16'(b_i);
endmodule

module mac_accum8 #(
   parameter int unsigned ACC_W = 24,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] out_count,
   output logic             overflow
);
   localparam int unsigned PROD_W = 16;
   localparam int unsigned SUM_W  = ACC_W + 1;

   typedef enum logic {ST_ACCUM, ST_HOLD} state_e;

   state_e             state_q, state_d;
   logic [PROD_W-1:0]  prod;
   logic [PROD_W-1:0]  prod_q, prod_d;
   logic               p_valid_q, p_valid_d;
   logic               last_q, last_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   acc_out_q, acc_out_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;
   logic               overflow_q, overflow_d;

   logic               accept;
   logic               consume;
   logic [SUM_W-1:0]   sum;

   multi8 u_mul (
      .a_i (a),
      .b_i (b),
      .p_o (prod)
   );

   // Stage 2 only drains the product register while not holding a result.
   assign consume  = p_valid_q && (state_q == ST_ACCUM);
   // The product register can refill in the same cycle it is being drained.
   assign in_ready = !p_valid_q || consume;
   assign accept   = in_valid && in_ready;

   // Extra top bit is the carry-out used for the sticky overflow flag.
   assign sum = {1'b0, acc_q} + SUM_W'(prod_q);

   // Next-state logic for both pipeline stages and the result handshake.
   always_comb begin
      state_d     = state_q;
      prod_d      = prod_q;
      p_valid_d   = p_valid_q;
      last_d      = last_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      acc_out_d   = acc_out_q;
      out_count_d = out_count_q;
      overflow_d  = overflow_q;

      if (accept) begin
         prod_d    = prod;
         last_d    = in_last;
         p_valid_d = 1'b1;
      end else if (consume) begin
         p_valid_d = 1'b0;
      end

      case (state_q)
         ST_ACCUM: begin
            if (consume) begin
               if (last_q) begin
                  acc_out_d   = sum[ACC_W-1:0];
                  out_count_d = cnt_q + CNT_W'(1);
                  overflow_d  = ovf_q | sum[ACC_W];
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  cnt_d       = '0;
                  ovf_d       = 1'b0;
                  state_d     = ST_HOLD;
               end else begin
                  acc_d = sum[ACC_W-1:0];
                  cnt_d = cnt_q + CNT_W'(1);
                  ovf_d = ovf_q | sum[ACC_W];
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   // State register; reset discards any partial packet and pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACCUM;
         prod_q      <= '0;
         p_valid_q   <= 1'b0;
         last_q      <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         acc_out_q   <= '0;
         out_count_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         prod_q      <= prod_d;
         p_valid_q   <= p_valid_d;
         last_q      <= last_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         acc_out_q   <= acc_out_d;
         out_count_q <= out_count_d;
         overflow_q  <= overflow_d;
      end
   end

   assign out_valid = out_valid_q;
   assign acc_out   = acc_out_q;
   assign out_count = out_count_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_accum8.sv
// Testbench for mac_accum8: directed scenarios plus randomized packets with random
// output backpressure. Two instances (ACC_W=24 and ACC_W=16) share all inputs; a
// packet-level reference model predicts each result from the accepted beats.
module tb_mac_accum8;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        in_last;
   logic        out_ready;

   logic        in_ready, out_valid, overflow;
   logic [23:0] acc_out;
   logic [7:0]  out_count;

   logic        in_ready16, out_valid16, overflow16;
   logic [15:0] acc_out16;
   logic [7:0]  out_count16;

   mac_accum8 #(.ACC_W(24), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .acc_out(acc_out), .out_count(out_count), .overflow(overflow)
   );

   mac_accum8 #(.ACC_W(16), .CNT_W(8)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
      .a(a), .b(b), .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready),
      .acc_out(acc_out16), .out_count(out_count16), .overflow(overflow16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: packet sum as an unbounded integer; a carry occurred at least
   // once exactly when the (monotone) sum reached 2^W.
   typedef struct {
      logic [23:0] acc24;
      logic [15:0] acc16;
      logic [7:0]  cnt;
      logic        ovf24;
      logic        ovf16;
   } exp_t;

   exp_t    exp_q[$];
   longint  run_sum = 0;
   int      run_cnt = 0;
   exp_t    e;
   exp_t    r;

   always @(negedge rst_n) begin
      exp_q.delete();
      run_sum = 0;
      run_cnt = 0;
   end

   // Beat acceptance side of the model.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         run_sum = run_sum + longint'(a) * longint'(b);
         run_cnt++;
         if (in_last) begin
            e.acc24 = 24'(run_sum);
            e.acc16 = 16'(run_sum);
            e.cnt   = 8'(run_cnt);
            e.ovf24 = (run_sum >= 64'h100_0000);
            e.ovf16 = (run_sum >= 64'h1_0000);
            exp_q.push_back(e);
            run_sum = 0;
            run_cnt = 0;
         end
      end
   end

   // Result side: compare every result the consumer takes.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(out_valid), 32'd0);
         end else begin
            r = exp_q.pop_front();
            check("acc_out",      32'(acc_out),     32'(r.acc24));
            check("out_count",    32'(out_count),   32'(r.cnt));
            check("overflow",     32'(overflow),    32'(r.ovf24));
            check("out_valid16",  32'(out_valid16), 32'd1);
            check("acc_out16",    32'(acc_out16),   32'(r.acc16));
            check("out_count16",  32'(out_count16), 32'(r.cnt));
            check("overflow16",   32'(overflow16),  32'(r.ovf16));
         end
      end
   end

   // Random backpressure on the result port while enabled.
   logic bp_en = 1'b0;
   always @(posedge clk) begin
      if (bp_en) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at posedge+1; returns at posedge+1 after the edge that accepted the beat.
   task automatic send_beat(input logic [7:0] av, input logic [7:0] bv, input logic lst);
      int   n;
      logic took;
      n    = 0;
      took = 1'b0;
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      in_last  = lst;
      while (!took && n < 200) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!took) check("send_timeout", 32'(took), 32'd1);
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < max_cyc) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_done", 32'(exp_q.size() == 0 && !out_valid), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_acc_out"},   32'(acc_out),   32'd0);
      check({tag, "_out_count"}, 32'(out_count), 32'd0);
      check({tag, "_overflow"},  32'(overflow),  32'd0);
      check({tag, "_in_ready"},  32'(in_ready),  32'd1);
      check({tag, "_acc_out16"}, 32'(acc_out16), 32'd0);
      check({tag, "_in_ready16"}, 32'(in_ready16), 32'd1);
   endtask

   // Asserts reset between clock edges, checks outputs, releases away from an edge.
   task automatic async_reset(input string tag);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs(tag);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   int          len;
   logic [7:0]  av, bv;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = 8'd0;
      b         = 8'd0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      #1 check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single max-value beat and its latency.
      send_beat(8'd255, 8'd255, 1'b1);
      check("lat_edge1_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("lat_edge2_valid", 32'(out_valid), 32'd1);
      check("single_acc",      32'(acc_out),   32'd65025);
      check("single_cnt",      32'(out_count), 32'd1);
      check("single_ovf",      32'(overflow),  32'd0);
      drain(20);

      // Back-to-back packet with no stalls.
      check("b2b_ready0", 32'(in_ready), 32'd1);
      send_beat(8'd3, 8'd4, 1'b0);
      check("b2b_ready1", 32'(in_ready), 32'd1);
      send_beat(8'd10, 8'd20, 1'b0);
      check("b2b_ready2", 32'(in_ready), 32'd1);
      send_beat(8'd15, 8'd15, 1'b1);
      check("b2b_ready3", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("b2b_acc", 32'(acc_out), 32'd437);
      check("b2b_cnt", 32'(out_count), 32'd3);
      drain(20);

      // 16-bit wrap with overflow, then a clean packet clears the flag.
      send_beat(8'd255, 8'd255, 1'b0);
      send_beat(8'd255, 8'd255, 1'b1);
      send_beat(8'd1, 8'd1, 1'b1);
      drain(20);

      // Output stall with one buffered beat behind it.
      out_ready = 1'b0;
      send_beat(8'd2, 8'd3, 1'b1);
      send_beat(8'd4, 8'd5, 1'b1);
      idle(3);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_acc",   32'(acc_out),   32'd6);
      check("hold_ready", 32'(in_ready),  32'd0);
      out_ready = 1'b1;
      drain(20);

      // Reset while holding a result and a buffered beat.
      out_ready = 1'b0;
      send_beat(8'd9, 8'd9, 1'b1);
      send_beat(8'd7, 8'd7, 1'b0);
      idle(2);
      check("prerst_ready", 32'(in_ready), 32'd0);
      async_reset("rst_hold");
      out_ready = 1'b1;

      // Reset mid-packet discards the partial sum.
      send_beat(8'd7, 8'd7, 1'b0);
      send_beat(8'd8, 8'd8, 1'b0);
      async_reset("rst_mid");
      send_beat(8'd2, 8'd3, 1'b1);
      @(posedge clk);
      #1;
      check("postrst_acc", 32'(acc_out),   32'd6);
      check("postrst_cnt", 32'(out_count), 32'd1);
      drain(20);

      // Idle cycles inside a packet.
      send_beat(8'd1, 8'd2, 1'b0);
      idle(3);
      send_beat(8'd3, 8'd4, 1'b1);
      @(posedge clk);
      #1;
      check("gap_acc", 32'(acc_out),   32'd14);
      check("gap_cnt", 32'(out_count), 32'd2);
      drain(20);

      // Randomized packets with backpressure; packet 20 is long and all-max.
      bp_en = 1'b1;
      for (int p = 0; p < 40; p++) begin
         len = (p == 20) ? 260 : int'($urandom_range(1, 6));
         for (int i = 0; i < len; i++) begin
            av = (p == 20) ? 8'hFF : 8'($urandom);
            bv = (p == 20) ? 8'hFF : 8'($urandom);
            send_beat(av, bv, (i == len - 1));
            idle(int'($urandom_range(0, 2)) * int'($urandom_range(0, 1)));
         end
      end
      bp_en = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      drain(200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
